// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin req/grant arbiter sharing one LED bank
// Owners keep the bank for at least MIN_SLOT cycles; an idle pattern shows while nobody owns it.
module led_bank_arbiter #(
  parameter int                NUM_REQ      = 4,
  parameter int                LED_W        = 8,
  parameter int                MIN_SLOT     = 16,
  parameter logic [LED_W-1:0]  IDLE_PATTERN = 8'h81
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         in_req,
  input  logic [NUM_REQ*LED_W-1:0]   in_leds,
  output logic [NUM_REQ-1:0]         out_grant,
  output logic                       out_busy,
  output logic [LED_W-1:0]           out_leds
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int SLOT_W = (MIN_SLOT > 1) ? $clog2(MIN_SLOT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]         state, nxt_state;
  logic [IDX_W-1:0]   owner, nxt_owner, rr_last, pick;
  logic [SLOT_W-1:0]  slot_cnt, nxt_slot;
  logic [NUM_REQ-1:0] others;
  logic               held, load;

  // First set candidate searching upward from rr_last+1 with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] win;
    logic             found;
    int               j;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(last) + k) % NUM_REQ;
      if (!found && cand[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
    return win;
  endfunction

  // out_grant is zero in IDLE, so "others" is simply every request there.
  assign others = in_req & ~out_grant;
  assign held   = in_req[owner];
  assign pick   = rr_pick(others, rr_last);

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_slot  = slot_cnt;
    load      = 1'b0;
    case (state)
      ST_IDLE: load = |others;
      ST_OWN, ST_HOLD: begin
        if (!held) begin
          if (|others) load = 1'b1;
          else         nxt_state = ST_IDLE;
        end else if (state == ST_OWN) begin
          if (slot_cnt != '0)  nxt_slot = slot_cnt - 1'b1;
          else if (|others)    load = 1'b1;
          else                 nxt_state = ST_HOLD;
        end else if (|others) begin
          load = 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
    if (load) begin
      nxt_state = ST_OWN;
      nxt_owner = pick;
      nxt_slot  = SLOT_W'(MIN_SLOT - 1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_last   <= IDX_W'(NUM_REQ - 1);
      slot_cnt  <= '0;
      out_grant <= '0;
      out_leds  <= IDLE_PATTERN;
    end else begin
      state    <= nxt_state;
      owner    <= nxt_owner;
      slot_cnt <= nxt_slot;
      if (load) rr_last <= pick;
      // Grant and data are registered together so a new owner's pattern lands with its grant.
      if (nxt_state == ST_IDLE) begin
        out_grant <= '0;
        out_leds  <= IDLE_PATTERN;
      end else begin
        out_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << nxt_owner;
        out_leds  <= in_leds[nxt_owner*LED_W +: LED_W];
      end
    end
  end

  assign out_busy = |out_grant;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - scoreboard bench for led_bank_arbiter
// Stimulus pushes per-cycle expected grant/leds; a monitor pops and compares after each edge.
module tb_led_bank_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  in_req;
  logic [31:0] in_leds;
  logic [3:0]  out_grant;
  logic        out_busy;
  logic [7:0]  out_leds;

  int checks = 0;
  int passed = 0;
  logic [11:0] exp_q[$];

  led_bank_arbiter #(.NUM_REQ(4), .LED_W(8), .MIN_SLOT(4), .IDLE_PATTERN(8'h81)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_req   (in_req),
    .in_leds  (in_leds),
    .out_grant(out_grant),
    .out_busy (out_busy),
    .out_leds (out_leds)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Called at a negedge: drive inputs for the next edge and queue what must follow it.
  task automatic cyc(input logic [3:0] req, input logic [31:0] leds,
                     input logic [3:0] eg, input logic [7:0] el);
    in_req  = req;
    in_leds = leds;
    exp_q.push_back({eg, el});
    @(negedge clock);
  endtask

  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", 32'(out_grant), 32'(e[11:8]));
        check("leds",  32'(out_leds),  32'(e[7:0]));
        check("busy",  32'(out_busy),  32'(|e[11:8]));
      end
    end
  end

  localparam logic [31:0] L  = {8'h44, 8'h33, 8'h22, 8'h11};
  localparam logic [31:0] L2 = {8'h44, 8'h55, 8'h22, 8'hAA};
  localparam logic [31:0] L3 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

  initial begin : stimulus
    int o;
    int waited;
    reset_n = 1'b0;
    in_req  = 4'b0000;
    in_leds = '0;
    @(negedge clock);
    @(negedge clock);
    check("reset_grant", 32'(out_grant), 32'h0);
    check("reset_leds",  32'(out_leds),  32'h81);
    check("reset_busy",  32'(out_busy),  32'h0);
    reset_n = 1'b1;

    // Reset mid-ownership, then regrant to 1 (rr_last back to 3).
    cyc(4'b0010, L, 4'b0010, 8'h22);
    cyc(4'b0010, L, 4'b0010, 8'h22);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_grant", 32'(out_grant), 32'h0);
    check("midrst_leds",  32'(out_leds),  32'h81);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(4'b0010, L, 4'b0010, 8'h22);
    cyc(4'b0000, L, 4'b0000, 8'h81);

    // Slot and switch: owner 0 for exactly 4 cycles, then 2 with its data on the same edge.
    cyc(4'b0001, L2, 4'b0001, 8'hAA);
    cyc(4'b0101, L2, 4'b0001, 8'hAA);
    cyc(4'b0101, L2, 4'b0001, 8'hAA);
    cyc(4'b0101, L2, 4'b0001, 8'hAA);
    cyc(4'b0101, L2, 4'b0100, 8'h55);
    cyc(4'b0000, L2, 4'b0000, 8'h81);

    // Early release: owner 1 drops with 3 pending, then 3 drops with nothing pending.
    cyc(4'b0010, L, 4'b0010, 8'h22);
    cyc(4'b1010, L, 4'b0010, 8'h22);
    cyc(4'b1000, L, 4'b1000, 8'h44);
    cyc(4'b0000, L, 4'b0000, 8'h81);

    // Fairness: rr_last=3, so owners go 0,1,2,3,... four cycles each with no gap.
    for (int k = 0; k < 40; k++) begin
      o = (k / 4) % 4;
      cyc(4'b1111, L3, 4'(1 << o), 8'(8'hA0 + 8'h11 * o));
    end

    // HOLD: sole requester 2 keeps the bank, then req0 takes it next cycle.
    for (int k = 0; k < 20; k++) cyc(4'b0100, L3, 4'b0100, 8'hC2);
    cyc(4'b0101, L3, 4'b0001, 8'hA0);

    // Datapath latency on owner 0.
    cyc(4'b0001, {24'h0, 8'h01}, 4'b0001, 8'h01);
    cyc(4'b0001, {24'h0, 8'h02}, 4'b0001, 8'h02);
    cyc(4'b0001, {24'h0, 8'h03}, 4'b0001, 8'h03);
    cyc(4'b0000, {24'h0, 8'h03}, 4'b0000, 8'h81);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
